spi_slave: RTL and testbench

//  SPI responder (slave) for the SPI master on the same board. Mode 3 (SCK idles high), MSB first, 1..32-bit words.

---
 rtl/spi_slave_pkg.sv | 32 +++
 rtl/spi_slave_if.sv | 26 ++
 rtl/spi_slave_pin_sync.sv | 54 +++++
 rtl/spi_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_slave.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types, sizes and small helpers for the SPI responder.
package spi_slave_pkg;

    localparam int SPI_MAX_BITS = 32;
    localparam int CNT_W        = 6;
    localparam logic [CNT_W-1:0] CNT_SAT = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Left-justify the outgoing word so that bit nbits lands at [31].
    function automatic logic [SPI_MAX_BITS-1:0] tx_align(
        input logic [SPI_MAX_BITS-1:0] data,
        input logic [4:0]              nbits_lo
    );
        logic [4:0] sh;
        sh = 5'd31 - nbits_lo;
        return data << sh;
    endfunction

    // A frame is in error unless exactly len+1 rising edges were seen.
    function automatic logic frame_len_err(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] len
    );
        return ({1'b0, cnt} != ({1'b0, len} + 7'd1));
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and FPGA-side signals of the SPI responder.
interface spi_slave_if;

    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_csn;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [31:0] tx_data;
    logic [5:0]  nbits;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        busy;

    modport slave (
        input  spi_sck, spi_mosi, spi_csn, tx_data, nbits,
        output spi_miso, spi_miso_oe, rx_data, rx_valid, rx_err, busy
    );

    modport master (
        output spi_sck, spi_mosi, spi_csn, tx_data, nbits,
        input  spi_miso, spi_miso_oe, rx_data, rx_valid, rx_err, busy
    );

endinterface

// File: rtl/spi_slave_pin_sync.sv
// Synchroniser plus history flop for one asynchronous SPI pin.
// Produces the synchronised level and registered rise/fall pulses,
// SYNC_STAGES+1 clk_in cycles after the pin edge.
module spi_slave_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic nrst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Next-state of the synchroniser chain and the edge compares.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
    end

    // Sampling chain is left free-running through reset so that a pin
    // already low when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk_in) begin
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    // Edge pulses are cleared by reset.
    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = hist_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 3 (SCK idles high), MSB first, 1..32-bit words.
// Oversamples SCK/MOSI/CSN in the clk_in domain and exposes the received
// word and the word to transmit as parallel registers.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic nrst,
    spi_slave_if.slave bus
);

    logic sck_rise;
    logic sck_fall;
    logic sck_lvl_unused;
    logic mosi_lvl;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic csn_rise;
    logic csn_fall;
    logic csn_lvl_unused;

    spi_slave_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_in (clk_in),
        .nrst   (nrst),
        .pin    (bus.spi_sck),
        .level  (sck_lvl_unused),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    spi_slave_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_in (clk_in),
        .nrst   (nrst),
        .pin    (bus.spi_mosi),
        .level  (mosi_lvl),
        .rise   (mosi_rise_unused),
        .fall   (mosi_fall_unused)
    );

    spi_slave_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk_in (clk_in),
        .nrst   (nrst),
        .pin    (bus.spi_csn),
        .level  (csn_lvl_unused),
        .rise   (csn_rise),
        .fall   (csn_fall)
    );

    state_e                  state_q,    state_d;
    logic [SPI_MAX_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_MAX_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]        len_q,      len_d;
    logic                    fall_pend_q, fall_pend_d;
    logic                    miso_q,     miso_d;
    logic                    miso_oe_q,  miso_oe_d;
    logic                    busy_q,     busy_d;
    logic [SPI_MAX_BITS-1:0] rx_data_q,  rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_err_q,   rx_err_d;

    // Frame FSM: next state, shift registers, bit counter and outputs.
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        fall_pend_d = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = rx_err_q;

        case (state_q)
            ST_IDLE: begin
                // A CSN fall seen during DONE is honoured here, one cycle late.
                if (csn_fall || fall_pend_q) begin
                    state_d    = ST_ACTIVE;
                    busy_d     = 1'b1;
                    miso_oe_d  = 1'b1;
                    miso_d     = 1'b1;
                    tx_shift_d = tx_align(bus.tx_data, bus.nbits[4:0]);
                    len_d      = bus.nbits;
                    bit_cnt_d  = 6'd0;
                    rx_shift_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACTIVE: begin
                // Deselect wins over any SCK event in the same cycle.
                if (csn_rise) begin
                    state_d   = ST_DONE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    if (sck_fall) begin
                        miso_d     = tx_shift_q[SPI_MAX_BITS-1];
                        tx_shift_d = {tx_shift_q[SPI_MAX_BITS-2:0], 1'b0};
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[SPI_MAX_BITS-2:0], mosi_lvl};
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end else begin
                        rx_shift_d = rx_shift_q;
                    end
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                rx_data_d   = rx_shift_q;
                rx_err_d    = frame_len_err(bit_cnt_q, len_q);
                rx_valid_d  = 1'b1;
                fall_pend_d = csn_fall;
            end

            default: begin
                state_d   = ST_IDLE;
                miso_oe_d = 1'b0;
                miso_d    = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            tx_shift_q  <= 32'd0;
            rx_shift_q  <= 32'd0;
            bit_cnt_q   <= 6'd0;
            len_q       <= 6'd0;
            fall_pend_q <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= 32'd0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            fall_pend_q <= fall_pend_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.busy        = busy_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_err      = rx_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-3 SPI master model drives the pins, MISO is
// read back by the master, received words are checked through a scoreboard.
module tb_spi_slave;

    localparam int H = 6;  // SCK half-period in clk_in cycles

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk_in = 1'b0;
    logic nrst   = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   valid_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk_in = ~clk_in;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_in (clk_in),
        .nrst   (nrst),
        .bus    (bus)
    );

    // Scoreboard: every rx_valid pulse pops and compares one expected frame.
    always @(negedge clk_in) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rx_valid rx_data=%h", bus.rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rx_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL rx_data got=%h exp=%h", bus.rx_data, mon_e.data);
                end
                checks++;
                if (bus.rx_err !== mon_e.err) begin
                    failures++;
                    $display("FAIL rx_err got=%b exp=%b (data %h)", bus.rx_err, mon_e.err, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic csn_low();
        bus.spi_csn = 1'b0;
        idle_cycles(H);
    endtask

    task automatic csn_high();
        idle_cycles(H);
        bus.spi_csn = 1'b1;
    endtask

    task automatic sck_bit(input logic mb, output logic sb);
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = mb;
        idle_cycles(H);
        bus.spi_sck = 1'b1;
        sb = bus.spi_miso;
        idle_cycles(H);
    endtask

    task automatic shift_bits(input logic [63:0] word, input int nclk, output logic [31:0] miso_w);
        logic b;
        miso_w = 32'd0;
        for (int i = 0; i < nclk; i++) begin
            sck_bit(word[nclk-1-i], b);
            miso_w = {miso_w[30:0], b};
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            idle_cycles(1);
            n++;
        end
        idle_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_rx_valid_timeout pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.spi_csn  = 1'b1;
        bus.spi_sck  = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 32'd0;
        bus.nbits    = 6'd0;
        nrst = 1'b0;
        idle_cycles(8);
        nrst = 1'b1;
        idle_cycles(1);
        checks++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.rx_valid, bus.rx_err, bus.busy} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=10000",
                     {bus.spi_miso, bus.spi_miso_oe, bus.rx_valid, bus.rx_err, bus.busy});
        end
        checks++;
        if (bus.rx_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_rx_data got=%h exp=0", bus.rx_data);
        end
    endtask

    task automatic test_word32();
        logic [31:0] mw;
        int v0;
        v0 = valid_cnt;
        bus.tx_data = 32'hDEAD_BEEF;
        bus.nbits   = 6'd31;
        push_exp(32'hA5A5_1234, 1'b0);
        csn_low();
        checks++;
        if ({bus.busy, bus.spi_miso_oe, bus.spi_miso} !== 3'b111) begin
            failures++;
            $display("FAIL selected_flags got=%b exp=111", {bus.busy, bus.spi_miso_oe, bus.spi_miso});
        end
        shift_bits(64'hA5A5_1234, 32, mw);
        csn_high();
        wait_drain("word32");
        checks++;
        if (mw !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL word32_miso got=%h exp=deadbeef", mw);
        end
        checks++;
        if (valid_cnt !== v0 + 1) begin
            failures++;
            $display("FAIL word32_valid_pulses got=%0d exp=1", valid_cnt - v0);
        end
        checks++;
        if ({bus.busy, bus.spi_miso_oe, bus.spi_miso} !== 3'b001) begin
            failures++;
            $display("FAIL deselected_flags got=%b exp=001", {bus.busy, bus.spi_miso_oe, bus.spi_miso});
        end
    endtask

    task automatic test_word8();
        logic [31:0] mw;
        bus.tx_data = 32'h0000_00C3;
        bus.nbits   = 6'd7;
        push_exp(32'h0000_003C, 1'b0);
        csn_low();
        shift_bits(64'h3C, 8, mw);
        csn_high();
        wait_drain("word8");
        checks++;
        if (mw !== 32'h0000_00C3) begin
            failures++;
            $display("FAIL word8_miso got=%h exp=000000c3", mw);
        end
    endtask

    task automatic test_one_bit();
        logic [31:0] mw;
        bus.tx_data = 32'h0000_0001;
        bus.nbits   = 6'd0;
        push_exp(32'h0000_0001, 1'b0);
        csn_low();
        shift_bits(64'h1, 1, mw);
        csn_high();
        wait_drain("one_bit");
        checks++;
        if (mw !== 32'h0000_0001) begin
            failures++;
            $display("FAIL one_bit_miso got=%h exp=00000001", mw);
        end
    endtask

    task automatic test_short_frame();
        logic [31:0] mw;
        bus.tx_data = 32'h0000_1234;
        bus.nbits   = 6'd15;
        push_exp(32'h0000_005A, 1'b1);
        csn_low();
        shift_bits(64'h5A, 8, mw);
        csn_high();
        wait_drain("short");
        checks++;
        if (mw !== 32'h0000_0012) begin
            failures++;
            $display("FAIL short_miso got=%h exp=00000012", mw);
        end
    endtask

    task automatic test_over_clocked();
        logic [31:0] mw;
        bus.tx_data = 32'hCAFE_F00D;
        bus.nbits   = 6'd31;
        push_exp(32'h1234_5678, 1'b1);
        csn_low();
        shift_bits(64'h2_1234_5678, 34, mw);
        csn_high();
        wait_drain("over");
        checks++;
        if (mw !== 32'h2BFB_C034) begin
            failures++;
            $display("FAIL over_miso_zero_fill got=%h exp=2bfbc034", mw);
        end
    endtask

    task automatic test_zero_edges();
        bus.nbits = 6'd7;
        push_exp(32'd0, 1'b1);
        csn_low();
        csn_high();
        wait_drain("zero_edges");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] mw;
        int v0;
        v0 = valid_cnt;
        bus.tx_data = 32'h1357_9BDF;
        bus.nbits   = 6'd31;
        csn_low();
        shift_bits(64'h3FF, 10, mw);
        nrst = 1'b0;
        idle_cycles(1);
        checks++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.rx_valid, bus.rx_err, bus.busy} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_flags got=%b exp=10000",
                     {bus.spi_miso, bus.spi_miso_oe, bus.rx_valid, bus.rx_err, bus.busy});
        end
        checks++;
        if (bus.rx_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_rx_data got=%h exp=0", bus.rx_data);
        end
        nrst = 1'b1;
        csn_high();
        idle_cycles(30);
        checks++;
        if (valid_cnt !== v0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_valid pulses=%0d busy=%b exp=0,0", valid_cnt - v0, bus.busy);
        end
        push_exp(32'h0F1E_2D3C, 1'b0);
        csn_low();
        shift_bits(64'h0F1E_2D3C, 32, mw);
        csn_high();
        wait_drain("after_reset");
        checks++;
        if (mw !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL after_reset_miso got=%h exp=13579bdf", mw);
        end
    endtask

    task automatic test_sck_while_deselected();
        logic [31:0] mw;
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.spi_sck = 1'b0;
            idle_cycles(H);
            bus.spi_sck = 1'b1;
            idle_cycles(H);
        end
        idle_cycles(20);
        checks++;
        if (valid_cnt !== v0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL sck_deselected pulses=%0d busy=%b exp=0,0", valid_cnt - v0, bus.busy);
        end
        bus.tx_data = 32'h0000_0000;
        bus.nbits   = 6'd15;
        push_exp(32'h0000_BEEF, 1'b0);
        csn_low();
        shift_bits(64'hBEEF, 16, mw);
        csn_high();
        wait_drain("beef");
    endtask

    task automatic test_back_to_back();
        logic [31:0] mw_a;
        logic [31:0] mw_b;
        int v0;
        v0 = valid_cnt;
        bus.tx_data = 32'h0000_0081;
        bus.nbits   = 6'd7;
        push_exp(32'h0000_0011, 1'b0);
        push_exp(32'h0000_0022, 1'b0);
        csn_low();
        shift_bits(64'h11, 8, mw_a);
        idle_cycles(H);
        bus.spi_csn = 1'b1;
        idle_cycles(1);
        csn_low();
        shift_bits(64'h22, 8, mw_b);
        csn_high();
        wait_drain("back_to_back");
        checks++;
        if (valid_cnt !== v0 + 2) begin
            failures++;
            $display("FAIL b2b_valid_pulses got=%0d exp=2", valid_cnt - v0);
        end
        checks++;
        if (mw_a !== 32'h81 || mw_b !== 32'h81) begin
            failures++;
            $display("FAIL b2b_miso got=%h,%h exp=81,81", mw_a, mw_b);
        end
    endtask

    initial begin
        test_reset();
        test_word32();
        test_word8();
        test_one_bit();
        test_short_frame();
        test_over_clocked();
        test_zero_edges();
        test_reset_midframe();
        test_sck_while_deselected();
        test_back_to_back();
        idle_cycles(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
